// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle trigger pulses into fixed-width output
// pulses separated by a mandatory low gap. Triggers arriving while a pulse is
// in progress are counted and replayed in order; excess triggers are dropped
// and flagged on overflow.
//
// The internal FSM, down-counter and pending counter react on the edge that
// samples trig. All ports are then driven from a second register stage that
// copies that internal state. As a result, out rises on the edge after the
// triggering edge.
//
// Optional build macro: PULSE_STRETCH_RETRIG_EN
//   When defined, a trigger during the high phase reloads the high counter,
//   which extends the current pulse instead of queueing a new one.
module pulse_stretcher #(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int MAX_CYC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Internal state (updated on the edge that samples trig)
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic                drop_q, drop_d;

  // Output register stage
  logic                out_q, out_d;
  logic                busy_q, busy_d;
  logic [PEND_W-1:0]   pending_q, pending_d;
  logic                overflow_q, overflow_d;

  // Add a trigger to the pending count. Bit PEND_W of the result is set
  // when the count is already full and the trigger must be dropped.
  function automatic logic [PEND_W:0] enqueue(input logic [PEND_W-1:0] p,
                                              input logic              t);
    logic [PEND_W:0] res;
    if (!t) begin
      res = {1'b0, p};
    end else if (p == PEND_MAX) begin
      res = {1'b1, p};
    end else begin
      res = {1'b0, p + PEND_ONE};
    end
    return res;
  endfunction

  // Next-state logic for the FSM, the phase counter and the pending count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    drop_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_HIGH;
          cnt_d   = HIGH_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
        pend_d = PEND_ZERO;
      end
      ST_HIGH: begin
`ifdef PULSE_STRETCH_RETRIG_EN
        if (trig) begin
          cnt_d = HIGH_LOAD;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
`else
        {drop_d, pend_d} = enqueue(pend_q, trig);
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
`endif
      end
      ST_GAP: begin
        if (cnt_q == CNT_ZERO) begin
          // A trigger on the replay edge offsets the replay, so the net pending
          // count is unchanged and no overflow is raised, even when full.
          if (trig) begin
            state_d = ST_HIGH;
            cnt_d   = HIGH_LOAD;
            pend_d  = pend_q;
          end else if (pend_q != PEND_ZERO) begin
            state_d = ST_HIGH;
            cnt_d   = HIGH_LOAD;
            pend_d  = pend_q - PEND_ONE;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
            pend_d  = PEND_ZERO;
          end
        end else begin
          cnt_d            = cnt_q - CNT_ONE;
          {drop_d, pend_d} = enqueue(pend_q, trig);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
        pend_d  = PEND_ZERO;
        drop_d  = 1'b0;
      end
    endcase
  end

  // Output stage values decoded from the current internal state
  always_comb begin
    out_d      = (state_q == ST_HIGH);
    busy_d     = (state_q != ST_IDLE);
    pending_d  = pend_q;
    overflow_d = drop_q;
  end

  // Internal state registers; async reset clears everything immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      pend_q  <= PEND_ZERO;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= 1'b0;
      busy_q     <= 1'b0;
      pending_q  <= PEND_ZERO;
      overflow_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      busy_q     <= busy_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign out      = out_q;
  assign busy     = busy_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Testbench for pulse_stretcher (HIGH_CYCLES=4, GAP_CYCLES=2, PEND_W=2).
// Each table row drives trig for one rising edge k. It also lists the outputs
// expected in the cycle that follows edge k.
module tb_pulse_stretcher;

  typedef struct {
    logic       t;
    logic       o;
    logic       b;
    logic [1:0] p;
    logic       v;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       trig;
  logic       out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  pulse_stretcher #(
    .HIGH_CYCLES(4),
    .GAP_CYCLES (2),
    .PEND_W     (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .trig    (trig),
    .out     (out),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  task automatic check(input string name, input int row, input logic [1:0] act,
                       input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0d, expected %0d", name, row, act, exp);
    end
  endtask

  task automatic addn(input int n, input logic t, input logic o, input logic b,
                      input logic [1:0] p, input logic v);
    vec_t r;
    r.t = t; r.o = o; r.b = b; r.p = p; r.v = v;
    for (int i = 0; i < n; i++) vecs.push_back(r);
  endtask

  // Apply the queued rows, starting from a negedge, then clear the queue
  task automatic run_vectors(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      trig = vecs[i].t;
      @(posedge clk);
      @(negedge clk);
      check({name, ".out"},      i, {1'b0, out},      {1'b0, vecs[i].o});
      check({name, ".busy"},     i, {1'b0, busy},     {1'b0, vecs[i].b});
      check({name, ".pending"},  i, pending,          vecs[i].p);
      check({name, ".overflow"}, i, {1'b0, overflow}, {1'b0, vecs[i].v});
    end
    trig = 1'b0;
    vecs.delete();
  endtask

  task automatic add_single();
    addn(1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    addn(4, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
    addn(2, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    addn(1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    rst  = 1'b1;
    trig = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.out",      0, {1'b0, out},      2'd0);
    check("reset.busy",     0, {1'b0, busy},     2'd0);
    check("reset.pending",  0, pending,          2'd0);
    check("reset.overflow", 0, {1'b0, overflow}, 2'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single trigger
    add_single();
    run_vectors("single");

    // Restart on the first edge after IDLE: low gap is GAP_CYCLES+1
    addn(1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    addn(4, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
    addn(2, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    addn(1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    addn(4, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
    addn(2, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    addn(1, 1'b0, 1'b0, 0, 2'd0, 1'b0);
    run_vectors("restart");

`ifndef PULSE_STRETCH_RETRIG_EN
    // Triggers at edges 0 and 2: one queued replay
    addn(1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    addn(1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
    addn(1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    addn(2, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
    addn(2, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    addn(4, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
    addn(2, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    addn(1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    run_vectors("queue1");

    // trig held at edges 0-5: saturate at 3, drop two, four pulses total
    addn(1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    addn(1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    addn(1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0);
    addn(1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0);
    addn(1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0);
    addn(1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1);
    addn(1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1);
    addn(4, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0);
    addn(2, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    addn(4, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
    addn(2, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    addn(4, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
    addn(2, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    addn(1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    run_vectors("saturate");

    // pending=1 with trig on the GAP-exit edge (edge 6)
    addn(1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    addn(1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
    addn(1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    addn(2, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
    addn(1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    addn(1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
    addn(4, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
    addn(2, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    addn(4, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
    addn(2, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    addn(1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    run_vectors("exit_trig");

    // pending=3 (full) with trig on the GAP-exit edge: no overflow
    addn(1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    addn(1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    addn(1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0);
    addn(1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0);
    addn(1, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0);
    addn(1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
    addn(1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0);
    addn(4, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0);
    addn(2, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
    addn(4, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0);
    addn(2, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    addn(4, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
    addn(2, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    addn(4, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
    addn(2, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    addn(1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    run_vectors("full_exit");

    // Asynchronous reset mid-pulse with pending=2
    trig = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    trig = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("pre_rst.pending", 0, pending,     2'd2);
    check("pre_rst.out",     0, {1'b0, out}, 2'd1);
    rst = 1'b1;
    #1;
    check("async_rst.out",      0, {1'b0, out},      2'd0);
    check("async_rst.busy",     0, {1'b0, busy},     2'd0);
    check("async_rst.pending",  0, pending,          2'd0);
    check("async_rst.overflow", 0, {1'b0, overflow}, 2'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    add_single();
    run_vectors("post_rst");
`else
    // Retrigger at edge 3 extends the pulse to cycles 1-7
    addn(1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    addn(2, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
    addn(1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    addn(4, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
    addn(2, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    addn(1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    run_vectors("retrig");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
Inverse of the level-to-pulse edge detection used on button inputs. Converts single-cycle trigger pulses into fixed-width output pulses, for LEDs, buzzers and strobes to downstream logic. Triggers that arrive while a pulse is in progress are counted and replayed in order after a mandatory low gap. Sits between edge-detected event sources and slow output drivers.

Parameters:
HIGH_CYCLES, 4, output high time per pulse in clk cycles; must be >= 1.
GAP_CYCLES, 2, minimum output low time between consecutive pulses in clk cycles; must be >= 1.
PEND_W, 2, width of the pending-trigger counter; holds at most PEND_MAX = 2^PEND_W - 1 triggers.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
trig  input  1  single-cycle trigger request, sampled on the rising edge of clk.
out  output  1  stretched pulse output; registered.
busy  output  1  high when state is not IDLE; registered.
pending  output  PEND_W  number of queued triggers not yet replayed; registered.
overflow  output  1  one-cycle pulse when a trigger is dropped because pending = PEND_MAX; registered.

Behaviour:
- Reset is asynchronous and active-high, and takes effect immediately, including mid-pulse. On reset:
  - state = IDLE; out = 0, busy = 0, pending = 0, overflow = 0; internal counter = 0.
- FSM states:
  - IDLE: out = 0, busy = 0.
  - HIGH: out = 1, busy = 1.
  - GAP: out = 0, busy = 1.
- Internal down-counter width is $clog2(max(HIGH_CYCLES, GAP_CYCLES)), minimum 1 bit.
- Transitions:
  - IDLE with trig = 1 -> HIGH, counter loaded with HIGH_CYCLES-1.
  - IDLE with trig = 0 -> stay in IDLE.
  - HIGH with counter = 0 -> GAP, counter loaded with GAP_CYCLES-1. Otherwise decrement.
  - GAP with counter = 0:
    - if the pending value in effect (after this cycle's trig) is > 0 -> HIGH, counter loaded with HIGH_CYCLES-1, pending decremented;
    - otherwise -> IDLE.
  - GAP with counter != 0 -> decrement.
- Latency: trig sampled at edge k puts out = 1 from edge k+1. out stays high for exactly HIGH_CYCLES cycles, then low for at least GAP_CYCLES cycles.
- Queueing: trig = 1 in HIGH or GAP increments pending if pending < PEND_MAX.
  - If pending = PEND_MAX, the trigger is dropped and overflow = 1 for the following cycle only.
- Simultaneous trig and replay on the same edge (GAP exit): net pending is unchanged and the trigger is not lost.
  - This holds even when pending = PEND_MAX, so no overflow is raised.
- pending is always 0 in IDLE.
- trig held high for N cycles counts as N triggers; no level-to-pulse conversion is done internally.
- A new pulse never starts from IDLE on the same edge as a GAP->IDLE transition. The earliest restart is the edge after IDLE is reached, so the gap is GAP_CYCLES+1 low cycles in that case.

Optional Feature:
PULSE_STRETCH_RETRIG_EN
- Defined: trig = 1 while in HIGH reloads the counter with HIGH_CYCLES-1, extending the current pulse. The trigger is not queued and overflow is not raised. trig during GAP is queued as normal.
- Undefined: trig during HIGH is queued exactly like trig during GAP, as described in Behaviour.

Test Plan:
Defaults HIGH_CYCLES=4, GAP_CYCLES=2, PEND_W=2; cycle numbers are counted from the trig edge.
1. Single trig at edge 0 -> out = 1 at cycles 1-4, busy = 1 at cycles 1-6, IDLE and busy = 0 at cycle 7; pending stays 0.
2. trig at edges 0 and 2 -> pending = 1 at cycle 3; out high at cycles 1-4, low at 5-6, high at 7-10; pending = 0 from cycle 7; busy = 0 at cycle 13.
3. trig at edge 0, then trig held high at edges 1-5 -> pending saturates at 3 by cycle 4. Triggers at edges 4 and 5 are dropped, with overflow = 1 at cycles 5 and 6. Exactly 4 output pulses result.
4. pending = 1 and trig asserted on the GAP-exit edge -> pending stays 1 across the replay and one further pulse follows; overflow is never raised.
5. rst asserted at cycle 2 of a pulse with pending = 2 -> out, busy and pending are 0 immediately, before the next clock edge. After release, a trig gives a normal 4-cycle pulse.
6. With PULSE_STRETCH_RETRIG_EN defined: trig at edges 0 and 3 -> out high at cycles 1-7, pending stays 0, GAP at cycles 8-9, IDLE at cycle 10.
